// File: rtl/muap_frame_tx.sv
// muap_frame_tx
//   Transmit-side framer for the multiplexed MUAP sample stream. Tags each
//   accepted sample with a channel index cycling 0..NUM_CH-1 and emits one
//   registered output word per sample. Exactly one word per frame carries
//   m_ch == NUM_CH-1 (m_eof).
//
// Optional build macro: MUAP_FRAME_HDR_EN
//   defined   : each frame starts with a header word (m_ch = 8'hFF,
//               m_data = frame number, m_sof = 1)
//   undefined : no header; m_sof marks the channel-0 data word
//
// Ports
//   clk, rst    clock, asynchronous active-high reset
//   en          framing enable, looked at in IDLE and on the last channel
//   s_data/s_valid/s_ready   sample input handshake
//   m_ch/m_data/m_valid/m_ready/m_sof/m_eof   framed output handshake
//   frame_No    completed frames since reset (wraps)
//   busy        state != IDLE or an output word is pending
//
// state   | meaning
// IDLE    | no frame in progress, waiting for en
// HDR     | header word waiting for a free output slot
// DATA    | accepting samples for channels 0..NUM_CH-1

module muap_frame_tx #(
    parameter int NUM_CH = 160,
    parameter int DW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [7:0]    m_ch,
    output logic [31:0]   m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_sof,
    output logic          m_eof,
    output logic [31:0]   frame_No,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

`ifdef MUAP_FRAME_HDR_EN
    localparam state_t FIRST_ST = ST_HDR;
`else
    localparam state_t FIRST_ST = ST_DATA;
`endif

    localparam logic [7:0] LAST_CH = 8'(NUM_CH - 1);

    state_t        state_q, state_d;
    logic [7:0]    ch_q, ch_d;
    logic [31:0]   frame_no_q, frame_no_d;
    logic          m_valid_q, m_valid_d;
    logic [7:0]    m_ch_q, m_ch_d;
    logic [31:0]   m_data_q, m_data_d;
    logic          m_sof_q, m_sof_d;
    logic          m_eof_q, m_eof_d;

    logic          slot_free;
    logic          s_ready_c;
    logic          accept;
    logic          last_ch;

    // Output register can take a new word when empty or being drained now.
    assign slot_free = !m_valid_q || m_ready;
    assign s_ready_c = (state_q == ST_DATA) && slot_free;
    assign accept    = s_valid && s_ready_c;
    assign last_ch   = (ch_q == LAST_CH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ch_q       <= '0;
            frame_no_q <= '0;
            m_valid_q  <= 1'b0;
            m_ch_q     <= '0;
            m_data_q   <= '0;
            m_sof_q    <= 1'b0;
            m_eof_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            frame_no_q <= frame_no_d;
            m_valid_q  <= m_valid_d;
            m_ch_q     <= m_ch_d;
            m_data_q   <= m_data_d;
            m_sof_q    <= m_sof_d;
            m_eof_q    <= m_eof_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (en) state_d = FIRST_ST;
            ST_HDR:  if (slot_free) state_d = ST_DATA;
            ST_DATA: if (accept && last_ch) state_d = en ? FIRST_ST : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        m_valid_d  = m_valid_q && !m_ready;
        m_ch_d     = m_ch_q;
        m_data_d   = m_data_q;
        m_sof_d    = m_sof_q;
        m_eof_d    = m_eof_q;
        ch_d       = ch_q;
        frame_no_d = frame_no_q;

`ifdef MUAP_FRAME_HDR_EN
        if (state_q == ST_HDR && slot_free) begin
            m_valid_d = 1'b1;
            m_ch_d    = 8'hFF;
            m_data_d  = frame_no_q;
            m_sof_d   = 1'b1;
            m_eof_d   = 1'b0;
            ch_d      = '0;
        end
`endif

        if (accept) begin
            m_valid_d = 1'b1;
            m_ch_d    = ch_q;
            m_data_d  = 32'(s_data);
`ifdef MUAP_FRAME_HDR_EN
            m_sof_d   = 1'b0;
`else
            m_sof_d   = (ch_q == 8'd0);
`endif
            m_eof_d   = last_ch;
            if (last_ch) begin
                ch_d       = '0;
                // Counts on the same edge that loads the eof word.
                frame_no_d = frame_no_q + 32'd1;
            end else begin
                ch_d = ch_q + 8'd1;
            end
        end
    end

    assign s_ready  = s_ready_c;
    assign m_valid  = m_valid_q;
    assign m_ch     = m_ch_q;
    assign m_data   = m_data_q;
    assign m_sof    = m_sof_q;
    assign m_eof    = m_eof_q;
    assign frame_No = frame_no_q;
    assign busy     = (state_q != ST_IDLE) || m_valid_q;

endmodule

// File: tb/tb_muap_frame_tx.sv
`timescale 1ns/1ps
module tb_muap_frame_tx;
    localparam int NUM_CH = 4;
    localparam int DW     = 16;
`ifdef MUAP_FRAME_HDR_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [7:0]    m_ch;
    logic [31:0]   m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_sof;
    logic          m_eof;
    logic [31:0]   frame_No;
    logic          busy;

    muap_frame_tx #(.NUM_CH(NUM_CH), .DW(DW)) dut (
        .clk(clk), .rst(rst), .en(en),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_ch(m_ch), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_sof(m_sof), .m_eof(m_eof), .frame_No(frame_No), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  ch;
        logic [31:0] data;
        logic        sof;
        logic        eof;
    } word_t;

    // Reference model: expected output words in order, plus frame bookkeeping.
    word_t         exp_q[$];
    word_t         log_q[$];
    int            log_cyc[$];
    logic [DW-1:0] feed[$];
    bit            m_idle = 1'b1;
    int            m_cnt = 0;
    logic [31:0]   m_frames = '0;
    int            cyc = 0;
    bit            acc_last = 1'b0;
    bit            frames_override = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    int p_valid = 100;
    int p_ready = 100;
    int stall_cnt = 0;
    bit rand_en = 1'b0;
    bit auto_feed = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_word(string name, int idx, logic [7:0] ch, logic [31:0] data,
                            logic sof, logic eof);
        chk({name, "_present"}, 32'(log_q.size() > idx), 32'd1);
        if (log_q.size() > idx) begin
            chk({name, "_ch"},   32'(log_q[idx].ch),  32'(ch));
            chk({name, "_data"}, log_q[idx].data,     data);
            chk({name, "_sof"},  32'(log_q[idx].sof), 32'(sof));
            chk({name, "_eof"},  32'(log_q[idx].eof), 32'(eof));
        end
    endtask

    // Compare process: checks DUT against the model each cycle at negedge,
    // then advances the model with the transfers about to happen on posedge.
    initial begin
        word_t         pv;
        word_t         w;
        logic          pstall;
        logic          pacc;
        logic          acc;
        logic [DW-1:0] psample;
        pstall = 1'b0;
        pacc = 1'b0;
        psample = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                m_idle = 1'b1;
                m_cnt = 0;
                m_frames = '0;
                pstall = 1'b0;
                pacc = 1'b0;
                acc_last = 1'b0;
            end else begin
                cyc++;
                if (frames_override) m_frames = 32'hFFFF_FFFF;
                chk("frame_no", frame_No, m_frames);
                chk("busy", 32'(busy), 32'(!m_idle || m_valid));
`ifdef MUAP_FRAME_HDR_EN
                chk("s_ready_allowed", 32'(s_ready && !(!m_idle && (!m_valid || m_ready))), 32'd0);
`else
                chk("s_ready", 32'(s_ready), 32'(!m_idle && (!m_valid || m_ready)));
`endif
                if (pstall) begin
                    chk("hold_valid", 32'(m_valid), 32'd1);
                    chk("hold_ch",    32'(m_ch), 32'(pv.ch));
                    chk("hold_data",  m_data, pv.data);
                    chk("hold_sof",   32'(m_sof), 32'(pv.sof));
                    chk("hold_eof",   32'(m_eof), 32'(pv.eof));
                end
                if (pacc) begin
                    chk("latency_valid", 32'(m_valid), 32'd1);
                    chk("latency_data",  m_data, 32'(psample));
                end
                if (m_valid && m_ready) begin
                    chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        w = exp_q.pop_front();
                        chk("sb_ch",   32'(m_ch), 32'(w.ch));
                        chk("sb_data", m_data, w.data);
                        chk("sb_sof",  32'(m_sof), 32'(w.sof));
                        chk("sb_eof",  32'(m_eof), 32'(w.eof));
                    end
                    log_q.push_back('{ch: m_ch, data: m_data, sof: m_sof, eof: m_eof});
                    log_cyc.push_back(cyc);
                end

                acc = s_valid && s_ready;
                chk("accept_in_idle", 32'(acc && m_idle), 32'd0);
                if (m_idle) begin
                    if (en) begin
                        m_idle = 1'b0;
                        m_cnt = 0;
                        if (HDR) exp_q.push_back('{ch: 8'hFF, data: m_frames, sof: 1'b1, eof: 1'b0});
                    end
                end else if (acc) begin
                    exp_q.push_back('{ch: 8'(m_cnt), data: 32'(s_data),
                                      sof: (!HDR && m_cnt == 0), eof: (m_cnt == NUM_CH - 1)});
                    if (m_cnt == NUM_CH - 1) begin
                        m_cnt = 0;
                        m_frames = m_frames + 32'd1;
                        if (en) begin
                            if (HDR) exp_q.push_back('{ch: 8'hFF, data: m_frames, sof: 1'b1, eof: 1'b0});
                        end else begin
                            m_idle = 1'b1;
                        end
                    end else begin
                        m_cnt++;
                    end
                end
                pstall = m_valid && !m_ready;
                pv = '{ch: m_ch, data: m_data, sof: m_sof, eof: m_eof};
                pacc = acc;
                psample = s_data;
                acc_last = acc;
            end
        end
    end

    task automatic step();
        logic [DW-1:0] r;
        @(posedge clk);
        #1;
        if (acc_last && feed.size() > 0) void'(feed.pop_front());
        if (auto_feed && feed.size() < 2) begin
            r = DW'($urandom);
            feed.push_back(r);
        end
        s_valid = (feed.size() > 0) && ($urandom_range(99) < p_valid);
        s_data  = (feed.size() > 0) ? feed[0] : '0;
        if (stall_cnt > 0) begin
            m_ready = 1'b0;
            stall_cnt--;
        end else begin
            m_ready = ($urandom_range(99) < p_ready);
        end
        if (rand_en) en = ($urandom_range(99) < 60);
    endtask

    task automatic wait_drain(int max, bit need_idle, string name);
        int k;
        k = 0;
        while (!(feed.size() == 0 && exp_q.size() == 0 && !m_valid && (!need_idle || m_idle))
               && k < max) begin
            step();
            k++;
        end
        chk({name, "_drain"}, 32'(k < max), 32'd1);
    endtask

    task automatic chk_reset_outputs(string name);
        chk({name, "_m_valid"}, 32'(m_valid), 32'd0);
        chk({name, "_m_ch"},    32'(m_ch), 32'd0);
        chk({name, "_m_data"},  m_data, 32'd0);
        chk({name, "_m_sof"},   32'(m_sof), 32'd0);
        chk({name, "_m_eof"},   32'(m_eof), 32'd0);
        chk({name, "_s_ready"}, 32'(s_ready), 32'd0);
        chk({name, "_frame_No"}, frame_No, 32'd0);
        chk({name, "_busy"},    32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;
        rst = 1'b1;
        en = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        m_ready = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Three continuous frames, data 1..12, downstream always ready.
        base = log_q.size();
        for (int i = 1; i <= 12; i++) feed.push_back(DW'(i));
        en = 1'b1;
        wait_drain(200, 1'b0, "t1");
`ifdef MUAP_FRAME_HDR_EN
        chk_word("t1_hdr0", base + 0, 8'hFF, 32'd0, 1'b1, 1'b0);
        chk_word("t1_ch0",  base + 1, 8'd0, 32'd1, 1'b0, 1'b0);
        chk_word("t1_ch3",  base + 4, 8'd3, 32'd4, 1'b0, 1'b1);
        chk_word("t1_hdr1", base + 5, 8'hFF, 32'd1, 1'b1, 1'b0);
        chk_word("t1_hdr2", base + 10, 8'hFF, 32'd2, 1'b1, 1'b0);
        chk_word("t1_hdr3", base + 15, 8'hFF, 32'd3, 1'b1, 1'b0);
        chk("t1_no_gaps", 32'(log_cyc[base + 15] - log_cyc[base]), 32'd15);
`else
        chk_word("t1_f0ch0", base + 0, 8'd0, 32'd1, 1'b1, 1'b0);
        chk_word("t1_f0ch3", base + 3, 8'd3, 32'd4, 1'b0, 1'b1);
        chk_word("t1_f1ch0", base + 4, 8'd0, 32'd5, 1'b1, 1'b0);
        chk_word("t1_f2ch3", base + 11, 8'd3, 32'd12, 1'b0, 1'b1);
        chk("t1_no_gaps", 32'(log_cyc[base + 11] - log_cyc[base]), 32'd11);
`endif
        chk("t1_frame_No", frame_No, 32'd3);

        // Downstream stall for 5 cycles in the middle of a frame.
        base = log_q.size();
        for (int i = 0; i < 4; i++) feed.push_back(DW'(100 + i));
        k = 0;
        while (log_q.size() < base + 2 && k < 50) begin step(); k++; end
        chk("t2_reach", 32'(k < 50), 32'd1);
        stall_cnt = 5;
        wait_drain(100, 1'b0, "t2");
        chk_word("t2_ch1", base + 1, 8'd1, 32'd101, 1'b0, 1'b0);
        chk_word("t2_ch2", base + 2, 8'd2, 32'd102, 1'b0, 1'b0);
        chk_word("t2_ch3", base + 3, 8'd3, 32'd103, 1'b0, 1'b1);

        // en dropped after channel 1: frame still completes, then IDLE.
        base = log_q.size();
        for (int i = 0; i < 4; i++) feed.push_back(DW'(200 + i));
        k = 0;
        while (m_cnt < 2 && k < 50) begin step(); k++; end
        chk("t3_reach", 32'(k < 50), 32'd1);
        en = 1'b0;
        wait_drain(100, 1'b1, "t3");
        repeat (3) step();
        chk("t3_words", 32'(log_q.size() - base), 32'd4);
        chk_word("t3_ch3", base + 3, 8'd3, 32'd203, 1'b0, 1'b1);
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_frame_No", frame_No, 32'd5);

        // Randomized traffic with random en and backpressure.
        p_valid = 70;
        p_ready = 70;
        rand_en = 1'b1;
        auto_feed = 1'b1;
        repeat (3000) step();
        rand_en = 1'b0;
        en = 1'b0;
        k = 0;
        while (!m_idle && k < 2000) begin step(); k++; end
        chk("rand_idle", 32'(k < 2000), 32'd1);
        auto_feed = 1'b0;
        feed.delete();
        p_ready = 100;
        wait_drain(100, 1'b1, "rand");
        p_valid = 100;

        // Reset in the middle of a frame.
        en = 1'b1;
        for (int i = 0; i < 4; i++) feed.push_back(DW'(300 + i));
        k = 0;
        while (m_cnt < 2 && k < 50) begin step(); k++; end
        chk("t5_reach", 32'(k < 50), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("t5_rst");
        feed.delete();
        en = 1'b0;
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        base = log_q.size();
        en = 1'b1;
        for (int i = 0; i < 4; i++) feed.push_back(DW'(400 + i));
        k = 0;
        while (m_cnt < 1 && k < 50) begin step(); k++; end
        en = 1'b0;
        wait_drain(100, 1'b1, "t5");
`ifdef MUAP_FRAME_HDR_EN
        chk_word("t5_hdr", base + 0, 8'hFF, 32'd0, 1'b1, 1'b0);
        chk_word("t5_ch0", base + 1, 8'd0, 32'd400, 1'b0, 1'b0);
`else
        chk_word("t5_ch0", base + 0, 8'd0, 32'd400, 1'b1, 1'b0);
`endif
        chk("t5_frame_No", frame_No, 32'd1);

        // Frame counter wrap.
        @(posedge clk);
        #1;
        force dut.frame_no_q = 32'hFFFF_FFFF;
        frames_override = 1'b1;
        step();
        step();
        release dut.frame_no_q;
        frames_override = 1'b0;
        base = log_q.size();
        en = 1'b1;
        for (int i = 0; i < 4; i++) feed.push_back(DW'(500 + i));
        k = 0;
        while (m_cnt < 1 && k < 50) begin step(); k++; end
        en = 1'b0;
        wait_drain(100, 1'b1, "t6");
`ifdef MUAP_FRAME_HDR_EN
        chk_word("t6_hdr", base + 0, 8'hFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        chk_word("t6_ch3", base + 4, 8'd3, 32'd503, 1'b0, 1'b1);
`else
        chk_word("t6_ch3", base + 3, 8'd3, 32'd503, 1'b0, 1'b1);
`endif
        chk("t6_frame_No_wrap", frame_No, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muap_frame_tx.md
Name: muap_frame_tx

Overview:
- Transmit-side framer for the multiplexed MUAP sample stream.
- Accepts per-channel samples on a valid/ready input and tags each with a channel index cycling 0..NUM_CH-1.
- Emits one framed word per sample, plus an optional frame-number header per frame.
- Produces the channel sequence that downstream frame counting consumes: exactly one word with m_ch==NUM_CH-1 per frame.

Parameters:
NUM_CH, 160, channels per frame; legal range 2..254 (255 reserved for header tag)
DW, 16, input sample width; legal range 1..32

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
en  in  1  framing enable; sampled only at frame boundaries
s_data  in  DW  input sample for current channel
s_valid  in  1  input sample valid
s_ready  out  1  input sample accepted when s_valid&&s_ready
m_ch  out  8  channel index of output word; 8'hFF = header
m_data  out  32  output word; zero-extended sample or frame number
m_valid  out  1  output word valid
m_ready  in  1  downstream accept
m_sof  out  1  first word of frame
m_eof  out  1  last word of frame (m_ch==NUM_CH-1)
frame_No  out  32  count of completed frames since reset
busy  out  1  high whenever state!=IDLE or m_valid

Behaviour:
- Reset (async): state=IDLE; ch=0; frame_No=0; m_valid=0; m_ch=0; m_data=0; m_sof=0; m_eof=0; s_ready=0. A partial frame in flight is discarded, with no further output.
- Output register: slot_free = !m_valid || m_ready. While m_valid&&!m_ready, m_ch, m_data, m_sof and m_eof hold stable. m_valid drops the cycle after acceptance unless a new word loads.
- s_ready = (state==DATA) && slot_free. Combinational from state and m_ready. No dependence on s_valid.
- Latency: a sample accepted at edge N appears on m_* after edge N, i.e. one register stage. Full throughput of 1 word/cycle is achieved with m_ready held high.
- States:
  - IDLE: if en=1, go to HDR.
  - HDR: when slot_free, load m_ch=8'hFF, m_data=frame_No, m_sof=1, m_eof=0, m_valid=1; go to DATA with ch=0.
  - DATA: on each accepted sample, load m_ch=ch, m_data={0,s_data}, m_sof=0, m_eof=(ch==NUM_CH-1), m_valid=1.
    - If ch<NUM_CH-1: ch<=ch+1.
    - Else: ch<=0; frame_No<=frame_No+1 (wraps 32'hFFFFFFFF->0). Go to HDR if en=1, otherwise IDLE.
- en deasserted mid-frame: the frame always completes all NUM_CH channels; en is checked only at the last-channel acceptance or in IDLE.
- s_valid low in DATA: no output loads; the channel index holds; no timeout.
- Back-to-back frames: the header is loaded on the cycle after the last sample is accepted, provided slot_free.
- frame_No increments in the same edge that loads the eof word.

Optional Feature:
- Macro: MUAP_FRAME_HDR_EN.
- Defined: HDR state and header word exist as described above.
- Undefined:
  - No header word; IDLE and last-channel transitions go directly to DATA.
  - m_sof=1 on the ch==0 data word.
  - m_ch never equals 8'hFF.
  - Frame length on m_* is NUM_CH words instead of NUM_CH+1.

Test Plan:
- Reset, en=1, NUM_CH=4, s_valid=1 with s_data=1,2,3,4, m_ready=1 -> header (ch FF, data 0, sof); then ch 0..3 with data 1..4; eof on ch 3; frame_No=1 after the eof word.
- Three frames continuous with m_ready=1 -> no idle cycles between frames; header data 0,1,2; frame_No=3.
- m_ready low for 5 cycles mid-frame -> m_* stable throughout; s_ready=0; no sample lost or duplicated.
- en dropped at ch 1 of 4 -> ch 2,3 still emitted; state returns to IDLE; busy=0 after the last word is accepted; no new header.
- Reset asserted at ch 2 -> all outputs 0 immediately; after release with en=1, the next header carries data 0.
- Preload frame_No to 32'hFFFFFFFF (force), complete a frame -> frame_No=0. Build without MUAP_FRAME_HDR_EN -> sof on ch 0 and no FF word.
